// File: rtl/rom_scanner_if.sv
// Bundle of scan control, ROM bus and result status signals for rom_scanner.
// The scanner drives the ROM address/enable and the status; the host drives everything else.
interface rom_scanner_if #(
  parameter int EXPECT_W = 16
) ();
  logic                start;
  logic                abort;
  logic [9:0]          first_addr;
  logic [9:0]          last_addr;
  logic [EXPECT_W-1:0] expected_sum;
  logic                rom_enable;
  logic [9:0]          rom_A;
  logic                rom_OE;
  logic [7:0]          rom_DO;
  logic                busy;
  logic                done;
  logic                pass;
  logic                oe_err;
  logic [EXPECT_W-1:0] sum;
  logic [10:0]         count;

  modport slave (
    input  start, abort, first_addr, last_addr, expected_sum, rom_OE, rom_DO,
    output rom_enable, rom_A, busy, done, pass, oe_err, sum, count
  );

  modport master (
    output start, abort, first_addr, last_addr, expected_sum, rom_OE, rom_DO,
    input  rom_enable, rom_A, busy, done, pass, oe_err, sum, count
  );
endinterface

// File: rtl/rom_scanner.sv
// Streams a wrapping address range out of a one-cycle-latency ROM, one byte per clock,
// and compares the running byte checksum with a reference value.
//
// state  | meaning
// IDLE   | waiting for start; results from the last scan held
// PRIME  | first address issued, nothing to sample yet
// STREAM | issue next address, sample byte of previous address
// DRAIN  | last address held, sample final byte
// DONE   | one-cycle done pulse with final results
module rom_scanner #(
  parameter int EXPECT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  rom_scanner_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [9:0]          addr_q, addr_d;
  logic [9:0]          last_q, last_d;
  logic [EXPECT_W-1:0] exp_q, exp_d;
  logic [EXPECT_W-1:0] sum_q, sum_d;
  logic [10:0]         count_q, count_d;
  logic                pass_q, pass_d;
  logic                oe_err_q, oe_err_d;
  logic                sample;
  logic                finish;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      last_q   <= '0;
      exp_q    <= '0;
      sum_q    <= '0;
      count_q  <= '0;
      pass_q   <= 1'b0;
      oe_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      last_q   <= last_d;
      exp_q    <= exp_d;
      sum_q    <= sum_d;
      count_q  <= count_d;
      pass_q   <= pass_d;
      oe_err_q <= oe_err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    last_d         = last_q;
    exp_d          = exp_q;
    sum_d          = sum_q;
    count_d        = count_q;
    pass_d         = pass_q;
    oe_err_d       = oe_err_q;
    sample         = 1'b0;
    finish         = 1'b0;
    bus.rom_enable = 1'b0;
    bus.rom_A      = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d  = S_PRIME;
          addr_d   = bus.first_addr;
          last_d   = bus.last_addr;
          exp_d    = bus.expected_sum;
          sum_d    = '0;
          count_d  = '0;
          pass_d   = 1'b0;
          oe_err_d = 1'b0;
        end
      end
      S_PRIME: begin
        bus.rom_enable = 1'b1;
        bus.rom_A      = addr_q;
        addr_d         = addr_q + 10'd1;
        if (bus.abort)              state_d = S_IDLE;
        else if (addr_q == last_q)  state_d = S_DRAIN;
        else                        state_d = S_STREAM;
      end
      S_STREAM: begin
        bus.rom_enable = 1'b1;
        bus.rom_A      = addr_q;
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          sample = 1'b1;
          addr_d = addr_q + 10'd1;
          if (addr_q == last_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        bus.rom_enable = 1'b1;
        bus.rom_A      = last_q;
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          sample  = 1'b1;
          finish  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A byte flagged invalid still counts as a sample but contributes nothing to the sum.
    if (sample) begin
      count_d = count_q + 11'd1;
      if (bus.rom_OE) sum_d    = sum_q + EXPECT_W'(bus.rom_DO);
      else            oe_err_d = 1'b1;
    end

    // Verdict is formed from the post-sample values so it is already valid during DONE.
    if (finish) pass_d = (sum_d == exp_q) && !oe_err_d;
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.pass   = pass_q;
  assign bus.oe_err = oe_err_q;
  assign bus.sum    = sum_q;
  assign bus.count  = count_q;

endmodule

// File: tb/tb_rom_scanner.sv
// Directed bench for rom_scanner: table of full scans plus hand-written wrap, single-byte,
// abort and mid-scan reset sequences against a behavioural one-cycle ROM.
module tb_rom_scanner;

  logic clk = 1'b0;
  logic rst;
  logic oe_kill;
  logic [7:0] rom_mem [1024];
  logic [9:0] addr_hist [8];
  int total = 0;
  int bad   = 0;
  int lat;

  rom_scanner_if #(.EXPECT_W(16)) bus ();

  rom_scanner #(.EXPECT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.rom_OE = bus.rom_enable & ~oe_kill;
  always @(posedge clk) bus.rom_DO <= rom_mem[bus.rom_A];

  typedef struct {
    logic [9:0]  first;
    logic [9:0]  last;
    logic [7:0]  fill;
    logic [15:0] exp_in;
    int          kill_cyc;
    int          restart_cyc;
    int          e_lat;
    int          e_count;
    logic [15:0] e_sum;
    logic        e_pass;
    logic        e_oe;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fill_rom(input logic [7:0] v);
    for (int i = 0; i < 1024; i++) rom_mem[i] = v;
  endtask

  // Called at a negedge; start is accepted on the following posedge (cycle 0).
  // lat returns the cycle index in which done was seen, or -1 if it never came.
  task automatic run_scan(input logic [9:0] f, input logic [9:0] l, input logic [15:0] e,
                          input int kill, input int restart, input int abrt, input int rstc,
                          input int maxc, output int lat_o);
    bus.first_addr   = f;
    bus.last_addr    = l;
    bus.expected_sum = e;
    bus.abort        = 1'b0;
    bus.start        = 1'b1;
    @(posedge clk);
    lat_o = -1;
    for (int cyc = 1; cyc <= maxc; cyc++) begin
      @(negedge clk);
      bus.start = (cyc == restart);
      bus.abort = (cyc == abrt);
      oe_kill   = (cyc == kill);
      if (cyc <= 8) addr_hist[cyc-1] = bus.rom_A;
      if (cyc == rstc) begin
        #1 rst = 1'b1;
        #1 chk("rst_async_zero", {bus.rom_enable, bus.rom_A, bus.busy, bus.done, bus.pass,
                                  bus.oe_err, bus.sum, bus.count}, 0);
        #1 rst = 1'b0;
      end
      if (bus.done) begin
        lat_o = cyc;
        break;
      end
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    oe_kill   = 1'b0;
  endtask

  initial begin
    logic [9:0] exp_a [4];

    vecs[0] = '{10'h000, 10'h3FF, 8'hFF, 16'hFC00, -1, -1, 1026, 1024, 16'hFC00, 1'b1, 1'b0};
    vecs[1] = '{10'h010, 10'h017, 8'h11, 16'h0088, -1,  3,   10,    8, 16'h0088, 1'b1, 1'b0};
    vecs[2] = '{10'h100, 10'h104, 8'h80, 16'h0000, -1, -1,    7,    5, 16'h0280, 1'b0, 1'b0};
    vecs[3] = '{10'h3FF, 10'h000, 8'h7F, 16'h00FE, -1, -1,    4,    2, 16'h00FE, 1'b1, 1'b0};
    vecs[4] = '{10'h001, 10'h000, 8'h01, 16'h0400, -1, -1, 1026, 1024, 16'h0400, 1'b1, 1'b0};
    vecs[5] = '{10'h020, 10'h027, 8'h10, 16'h0070,  4, -1,   10,    8, 16'h0070, 1'b0, 1'b1};

    rst = 1'b1;
    oe_kill = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.first_addr = '0;
    bus.last_addr = '0;
    bus.expected_sum = '0;
    fill_rom(8'h00);
    repeat (2) @(negedge clk);
    chk("reset_outputs", {bus.rom_enable, bus.rom_A, bus.busy, bus.done, bus.pass,
                          bus.oe_err, bus.sum, bus.count}, 0);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      fill_rom(vecs[v].fill);
      run_scan(vecs[v].first, vecs[v].last, vecs[v].exp_in, vecs[v].kill_cyc,
               vecs[v].restart_cyc, -1, -1, vecs[v].e_lat + 5, lat);
      chk($sformatf("v%0d_done_cycle", v), lat, vecs[v].e_lat);
      chk($sformatf("v%0d_count", v), bus.count, vecs[v].e_count);
      chk($sformatf("v%0d_sum", v), bus.sum, vecs[v].e_sum);
      chk($sformatf("v%0d_pass", v), bus.pass, vecs[v].e_pass);
      chk($sformatf("v%0d_oe_err", v), bus.oe_err, vecs[v].e_oe);
      @(negedge clk);
      chk($sformatf("v%0d_idle_after", v), {bus.done, bus.busy, bus.rom_enable}, 0);
      chk($sformatf("v%0d_sum_hold", v), bus.sum, vecs[v].e_sum);
    end

    // Wrap from 0x3FE through 0x001
    fill_rom(8'h00);
    rom_mem[10'h3FE] = 8'h01;
    rom_mem[10'h3FF] = 8'h02;
    rom_mem[10'h000] = 8'h03;
    rom_mem[10'h001] = 8'h04;
    exp_a = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    run_scan(10'h3FE, 10'h001, 16'h000A, -1, -1, -1, -1, 20, lat);
    chk("wrap_done_cycle", lat, 6);
    chk("wrap_count", bus.count, 4);
    chk("wrap_sum", bus.sum, 16'h000A);
    chk("wrap_pass", bus.pass, 1);
    for (int i = 0; i < 4; i++) chk($sformatf("wrap_addr%0d", i), addr_hist[i], exp_a[i]);
    @(negedge clk);

    // Single byte: PRIME then DRAIN
    rom_mem[10'h155] = 8'hA5;
    run_scan(10'h155, 10'h155, 16'h00A5, -1, -1, -1, -1, 20, lat);
    chk("single_done_cycle", lat, 3);
    chk("single_count", bus.count, 1);
    chk("single_sum", bus.sum, 16'h00A5);
    chk("single_pass", bus.pass, 1);
    chk("single_addr_prime", addr_hist[0], 10'h155);
    chk("single_addr_drain", addr_hist[1], 10'h155);
    @(negedge clk);

    // Abort in the 10th STREAM cycle, then a clean rerun
    fill_rom(8'h03);
    run_scan(10'h040, 10'h053, 16'h003C, -1, -1, 11, -1, 40, lat);
    chk("abort_no_done", lat, -1);
    chk("abort_idle", {bus.busy, bus.rom_enable, bus.pass}, 0);
    run_scan(10'h040, 10'h053, 16'h003C, -1, -1, -1, -1, 30, lat);
    chk("rerun_done_cycle", lat, 22);
    chk("rerun_count", bus.count, 20);
    chk("rerun_sum", bus.sum, 16'h003C);
    chk("rerun_pass", bus.pass, 1);
    @(negedge clk);

    // start and abort together in IDLE: nothing starts, results held
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("abort_wins_busy", bus.busy, 0);
    chk("abort_wins_hold", bus.sum, 16'h003C);

    // Asynchronous reset mid-STREAM, then a normal scan
    fill_rom(8'h05);
    run_scan(10'h000, 10'h01F, 16'h00A0, -1, -1, -1, 8, 40, lat);
    chk("rst_no_done", lat, -1);
    chk("rst_idle", {bus.busy, bus.sum, bus.count}, 0);
    run_scan(10'h000, 10'h01F, 16'h00A0, -1, -1, -1, -1, 40, lat);
    chk("post_rst_done_cycle", lat, 34);
    chk("post_rst_count", bus.count, 32);
    chk("post_rst_sum", bus.sum, 16'h00A0);
    chk("post_rst_pass", bus.pass, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
